// File: rtl/wheels_pkg.sv
// -----------------------------------------------------------------------------
// wheels_pkg
// Shared constants and helpers for the wheel step-pulse ramp generator:
//   - ch_w()    : width of the channel index port, max(1, clog2(n))
//   - sat_add() : a + b, clamped to an upper limit
//   - sat_sub() : a - b, clamped to a lower floor
// The saturating helpers work on SAT_W bits with one extra carry/borrow bit,
// so any counter width up to SAT_W fits without wrap.
// -----------------------------------------------------------------------------
package wheels_pkg;

  localparam int DEF_START_PERIOD = 50000;
  localparam int DEF_RAMP_STEP    = 5000;
  localparam int SAT_W            = 64;

  // Channel index width; a single channel still gets a 1-bit index port.
  function automatic int ch_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // a + b computed with a carry bit, then clamped to lim.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end else begin
      return sum[SAT_W-1:0];
    end
  endfunction

  // a - b computed with a borrow bit, then clamped from below to floor.
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] floor);
    logic [SAT_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[SAT_W] || (diff[SAT_W-1:0] < floor)) begin
      return floor;
    end else begin
      return diff[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/wheel_ramp_ch.sv
// -----------------------------------------------------------------------------
// wheel_ramp_ch
// One wheel channel: holds the target period, the current (ramping) period and
// the interval down-counter, and emits a registered one-cycle step pulse each
// time the counter expires. The period moves toward the target by at most
// RAMP_STEP per pulse; a zero target ramps out to START_PERIOD and then stops.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_run              0 = hold all state, no pulses
//   i_wr_en            load i_wr_period into the target this edge
//   i_wr_period        new target period (0 = stop)
//   o_step             registered step pulse
//   o_active           current period nonzero
//   o_busy             current period differs from target
// -----------------------------------------------------------------------------
module wheel_ramp_ch
  import wheels_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_wr_en,
  input  logic [CNT_W-1:0] i_wr_period,
  output logic             o_step,
  output logic             o_active,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
  localparam logic [SAT_W-1:0] START_X = SAT_W'(START_PERIOD);
  localparam logic [SAT_W-1:0] STEP_X  = SAT_W'(RAMP_STEP);

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;

  logic [SAT_W-1:0] w_per_x;
  logic [SAT_W-1:0] w_tgt_x;
  logic [SAT_W-1:0] w_ramp_x;
  logic [CNT_W-1:0] w_ramp;
  logic [CNT_W-1:0] w_start;
  logic [CNT_W-1:0] w_target_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_step_nxt;

  // Ramp function: the period to load at the next pulse.
  always_comb begin
    w_per_x  = SAT_W'(r_period);
    w_tgt_x  = SAT_W'(r_target);
    w_ramp_x = w_per_x;
    if (r_target != {CNT_W{1'b0}}) begin
      if (r_period > r_target) begin
        w_ramp_x = sat_sub(w_per_x, STEP_X, w_tgt_x);
      end else if (r_period < r_target) begin
        w_ramp_x = sat_add(w_per_x, STEP_X, w_tgt_x);
      end else begin
        w_ramp_x = w_per_x;
      end
    end else begin
      // Stopping: slow down to START_PERIOD, then the next pulse is the last.
      if (r_period >= START_P) begin
        w_ramp_x = {SAT_W{1'b0}};
      end else begin
        w_ramp_x = sat_add(w_per_x, STEP_X, START_X);
      end
    end
    w_ramp = w_ramp_x[CNT_W-1:0];
  end

  // Next-state for target, period, counter and step pulse.
  always_comb begin
    w_start      = (r_target > START_P) ? r_target : START_P;
    w_period_nxt = r_period;
    w_cnt_nxt    = r_cnt;
    w_step_nxt   = 1'b0;
    if (i_wr_en) begin
      w_target_nxt = i_wr_period;
    end else begin
      w_target_nxt = r_target;
    end
    if (!i_run) begin
      w_period_nxt = r_period;
      w_cnt_nxt    = r_cnt;
    end else if (r_period == {CNT_W{1'b0}}) begin
      // Idle: start at no faster than START_PERIOD once a target exists.
      if (r_target != {CNT_W{1'b0}}) begin
        w_period_nxt = w_start;
        w_cnt_nxt    = w_start - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_period_nxt = r_period;
        w_cnt_nxt    = r_cnt;
      end
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_step_nxt   = 1'b1;
      w_period_nxt = w_ramp;
      if (w_ramp == {CNT_W{1'b0}}) begin
        w_cnt_nxt = {CNT_W{1'b0}};
      end else begin
        w_cnt_nxt = w_ramp - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_target <= {CNT_W{1'b0}};
      r_period <= {CNT_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_step   <= 1'b0;
    end else begin
      r_target <= w_target_nxt;
      r_period <= w_period_nxt;
      r_cnt    <= w_cnt_nxt;
      r_step   <= w_step_nxt;
    end
  end

  assign o_step   = r_step;
  assign o_active = (r_period != {CNT_W{1'b0}});
  assign o_busy   = (r_period != r_target);

endmodule

// File: rtl/wheel_pulse_ramp_gen.sv
// -----------------------------------------------------------------------------
// wheel_pulse_ramp_gen
// Multi-channel wheel step-pulse generator with acceleration limiting.
// Configuration writes use a valid/ready handshake; ready drops for one cycle
// after every accepted write. Writes to a channel index >= NUM_CH are dropped
// and set the sticky o_cfg_err flag.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_run              global gate; 0 freezes every channel
//   i_cfg_valid        write request
//   o_cfg_ready        write can be accepted this cycle
//   i_cfg_ch           target channel index
//   i_cfg_period       target period in clocks (0 = stop)
//   o_cfg_err          sticky bad-channel flag
//   o_step             per-channel registered step pulse
//   o_active           per-channel period nonzero
//   o_busy             per-channel period != target
// -----------------------------------------------------------------------------
module wheel_pulse_ramp_gen
  import wheels_pkg::*;
#(
  parameter int  NUM_CH       = 2,
  parameter int  CNT_W        = 32,
  parameter int  START_PERIOD = DEF_START_PERIOD,
  parameter int  RAMP_STEP    = DEF_RAMP_STEP,
  localparam int CH_W         = ch_w(NUM_CH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_period,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_step,
  output logic [NUM_CH-1:0] o_active,
  output logic [NUM_CH-1:0] o_busy
);

  logic              r_cfg_ready;
  logic              r_cfg_err;
  logic              w_accept;
  logic              w_ch_ok;
  logic [NUM_CH-1:0] w_wr_en;

  assign w_accept = i_cfg_valid & r_cfg_ready;
  assign w_ch_ok  = (int'(i_cfg_ch) < NUM_CH);

  // Address decode: one-hot write enable for the addressed channel.
  always_comb begin
    w_wr_en = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_accept && w_ch_ok && (i_cfg_ch == CH_W'(c))) begin
        w_wr_en[c] = 1'b1;
      end else begin
        w_wr_en[c] = 1'b0;
      end
    end
  end

  // Handshake throttle and sticky error flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_ready <= ~w_accept;
      if (w_accept && !w_ch_ok) begin
        r_cfg_err <= 1'b1;
      end else begin
        r_cfg_err <= r_cfg_err;
      end
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_err   = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wheel_ramp_ch #(
      .CNT_W        (CNT_W),
      .START_PERIOD (START_PERIOD),
      .RAMP_STEP    (RAMP_STEP)
    ) u_ch (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_run       (i_run),
      .i_wr_en     (w_wr_en[g]),
      .i_wr_period (i_cfg_period),
      .o_step      (o_step[g]),
      .o_active    (o_active[g]),
      .o_busy      (o_busy[g])
    );
  end

endmodule
